sync_bank_ctrl: RTL

//   Sequences a bank of WIDTH two-flop `synchronizer` cells that bring async pins into the clk domain.

---
 rtl/sync_ctrl_pkg.sv | 21 ++
 rtl/strobe_prescaler.sv | 41 ++++
 rtl/synchronizer.sv | 30 +++
 rtl/sync_bank_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sync_ctrl_pkg.sv
// ============================================================================
//  Module  : sync_ctrl_pkg
//  Brief   : Shared state encoding and flush depth for sync_bank_ctrl.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } sync_state_e;

  // Strobes needed to push stale data through both synchronizer flops
  localparam int FLUSH_STROBES = 2;

endpackage

`default_nettype wire

// File: rtl/strobe_prescaler.sv
// ============================================================================
//  Module  : strobe_prescaler
//  Brief   : Programmable divider producing a registered one-cycle strobe.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module strobe_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             sample_stb
);

  localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;

  // >= rather than == so a lowered div strobes immediately instead of wrapping
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt      <= '0;
      sample_stb <= 1'b0;
    end else if (!enable) begin
      r_cnt      <= '0;
      sample_stb <= 1'b0;
    end else if (r_cnt >= div) begin
      r_cnt      <= '0;
      sample_stb <= 1'b1;
    end else begin
      r_cnt      <= r_cnt + C_ONE;
      sample_stb <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/synchronizer.sv
// ============================================================================
//  Module  : synchronizer
//  Brief   : Two-flop synchronizer cell with sample enable.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module synchronizer (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  input  logic d,
  output logic q
);

  logic r_meta;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else if (en) begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_bank_ctrl.sv
// ============================================================================
//  Module  : sync_bank_ctrl
//  Brief   : Strobed synchronizer bank with flush gating and edge pulses.
//            Optional per-bit debounce filter: define SYNC_DEBOUNCE_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_bank_ctrl
  import sync_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DIV_W   = 8,
  parameter int DEB_LEN = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] async_in,
  output logic             sample_stb,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             valid
);

  localparam logic [1:0] C_FLUSH_LAST = 2'(FLUSH_STROBES - 1);

  sync_state_e      r_state;
  sync_state_e      w_state_nxt;
  logic [1:0]       r_flush_cnt;
  logic             r_stb_d;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] r_prev;
  logic             w_flush_done;

  if (DEB_LEN < 1) begin : g_deb_len_bad
    $error("DEB_LEN must be at least 1");
  end

  strobe_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk        (clk),
    .rstb       (rstb),
    .enable     (enable),
    .div        (div),
    .sample_stb (sample_stb)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    synchronizer u_sync (
      .clk  (clk),
      .rstb (rstb),
      .en   (sample_stb),
      .d    (async_in[i]),
      .q    (w_raw[i])
    );
  end

  // Synchronizer outputs carry fresh data in the cycle after the strobe
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_stb_d <= 1'b0;
    end else begin
      r_stb_d <= sample_stb;
    end
  end

`ifdef SYNC_DEBOUNCE_EN
  localparam int DEB_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEB_LEN - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic             r_filt;
    logic [DEB_W-1:0] r_deb_cnt;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_filt    <= 1'b0;
        r_deb_cnt <= '0;
      end else if (enable && r_stb_d) begin
        if (r_state == FLUSH) begin
          r_filt    <= w_raw[i];
          r_deb_cnt <= '0;
        end else if (r_state == RUN) begin
          if (w_raw[i] == r_filt) begin
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == C_DEB_LAST) begin
            r_filt    <= w_raw[i];
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
      end
    end

    assign sync_out[i] = r_filt;
  end
`else
  assign sync_out = w_raw;
`endif

  assign w_flush_done = r_stb_d && (r_flush_cnt == C_FLUSH_LAST);

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = FLUSH;
        FLUSH:   w_state_nxt = w_flush_done ? RUN : FLUSH;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= IDLE;
      r_flush_cnt <= 2'd0;
      r_prev      <= '0;
      rise        <= '0;
      fall        <= '0;
      valid       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      valid   <= (w_state_nxt == RUN);
      rise    <= '0;
      fall    <= '0;
      if (enable && (r_state == FLUSH)) begin
        if (r_stb_d) begin
          r_flush_cnt <= r_flush_cnt + 2'd1;
          r_prev      <= w_raw;
        end
      end else begin
        r_flush_cnt <= 2'd0;
      end
      if (enable && (r_state == RUN) && r_stb_d) begin
        rise   <= sync_out & ~r_prev;
        fall   <= ~sync_out & r_prev;
        r_prev <= sync_out;
      end
    end
  end

endmodule

`default_nettype wire
